// File: rtl/imm_pkg.sv
// Shared definitions for the immediate-extension pipeline: mode encodings
// and the PAIR-sequence FSM state type.
package imm_pkg;

    localparam logic [1:0] MODE_SIGN = 2'd0;
    localparam logic [1:0] MODE_ZERO = 2'd1;
    localparam logic [1:0] MODE_SHL1 = 2'd2;
    localparam logic [1:0] MODE_PAIR = 2'd3;

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        HI_HELD = 1'b1
    } pair_state_e;

endpackage

// File: rtl/imm_extend_pipe_if.sv
// Decoder-side beat handshake and ALU-side result handshake of the extender.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_imm;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [OUT_W-1:0]  out_data;
    logic              err;

    modport master (
        output in_valid, in_imm, in_mode, out_ready,
        input  in_ready, out_valid, out_data, err
    );

    modport slave (
        input  in_valid, in_imm, in_mode, out_ready,
        output in_ready, out_valid, out_data, err
    );
endinterface

// File: rtl/imm_extend_core.sv
// Combinational IN_W -> OUT_W extender: sign, zero, sign-then-shift-left-1,
// or {hi, imm} concatenation truncated to OUT_W bits.
module imm_extend_core
    import imm_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic [IN_W-1:0]  imm,
    input  logic [IN_W-1:0]  hi,
    input  logic [1:0]       mode,
    output logic [OUT_W-1:0] result
);
    logic signed [IN_W-1:0]  imm_s;
    logic signed [OUT_W-1:0] sext;
    logic [2*IN_W-1:0]       pair_cat;

    assign imm_s    = signed'(imm);
    assign sext     = OUT_W'(imm_s);
    assign pair_cat = {hi, imm};

    always_comb begin
        result = '0;
        case (mode)
            MODE_SIGN: result = $unsigned(sext);
            MODE_ZERO: result = OUT_W'(imm);
            // The bit shifted out of the top is simply dropped.
            MODE_SHL1: result = {$unsigned(sext[OUT_W-2:0]), 1'b0};
            MODE_PAIR: result = pair_cat[OUT_W-1:0];
            default:   result = '0;
        endcase
    end
endmodule

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender: PAIR-sequence FSM with held hi beat, feeding
// a 2-entry output FIFO that absorbs single-cycle ALU holds.
module imm_extend_pipe
    import imm_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    imm_extend_pipe_if.slave    bus
);
    pair_state_e      state;
    logic [IN_W-1:0]  hi_p0;
    logic [OUT_W-1:0] result_p0;
    logic [OUT_W-1:0] head_p1;
    logic [OUT_W-1:0] tail_p1;
    logic [1:0]       count;
    logic             err_p1;
    logic             accept;
    logic             pop;
    logic             push;
    logic             pair_start;
    logic             pair_break;

    imm_extend_core #(.IN_W(IN_W), .OUT_W(OUT_W)) u_core (
        .imm    (bus.in_imm),
        .hi     (hi_p0),
        .mode   (bus.in_mode),
        .result (result_p0)
    );

    assign bus.in_ready  = (count < 2'd2) || ((count == 2'd2) && bus.out_ready);
    assign bus.out_valid = (count != 2'd0);
    assign bus.out_data  = head_p1;
    assign bus.err       = err_p1;

    assign accept     = bus.in_valid && bus.in_ready;
    assign pop        = (count != 2'd0) && bus.out_ready;
    assign pair_start = accept && (state == IDLE) && (bus.in_mode == MODE_PAIR);
    assign pair_break = accept && (state == HI_HELD) && (bus.in_mode != MODE_PAIR);
    // A PAIR first beat occupies an input slot but produces nothing.
    assign push       = accept && !pair_start;

    // ---- stage p0: pair FSM and held hi beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            err_p1 <= 1'b0;
        end else if (flush) begin
            state  <= IDLE;
            err_p1 <= 1'b0;
        end else begin
            err_p1 <= pair_break;
            if (pair_start) begin
                state <= HI_HELD;
            end else if (accept) begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pair_start) begin
            hi_p0 <= bus.in_imm;
        end
    end

    // ---- stage p1: 2-entry output FIFO, head always in head_p1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 2'd0;
            head_p1 <= '0;
            tail_p1 <= '0;
        end else if (flush) begin
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head_p1 <= result_p0;
                    else               tail_p1 <= result_p0;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head_p1 <= tail_p1;
                    count   <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head_p1 <= result_p0;
                    end else begin
                        head_p1 <= tail_p1;
                        tail_p1 <= result_p0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_imm_extend_pipe.sv
// Self-checking bench for imm_extend_pipe: directed cases plus random traffic
// compared against a queue-based reference model.
module tb_imm_extend_pipe;
    localparam int IN_W  = 8;
    localparam int OUT_W = 16;

    logic clk;
    logic rst_n;
    logic flush;

    imm_extend_pipe_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

    imm_extend_pipe #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    longint exp_q[$];
    bit     m_held;
    longint m_hi;
    bit     m_err;

    logic [OUT_W-1:0] obs_data;
    logic             obs_valid;
    logic             obs_err;
    logic             obs_rdy;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Reference extension from the mode rules, using plain integer arithmetic.
    function automatic longint ref_ext(input int mode, input longint imm, input longint hi);
        longint msk;
        longint v;
        msk = (longint'(1) << OUT_W) - 1;
        v   = (imm >= (longint'(1) << (IN_W - 1))) ? imm - (longint'(1) << IN_W) : imm;
        case (mode)
            0:       return v & msk;
            1:       return imm & msk;
            2:       return (v * 2) & msk;
            default: return (hi * (longint'(1) << IN_W) + imm) & msk;
        endcase
    endfunction

    task automatic cycle(input bit v, input int imm, input int mode, input bit ordy, input bit fl);
        bit rdy_m;
        bit acc;
        bit nerr;
        @(negedge clk);
        bus.in_valid  = v;
        bus.in_imm    = IN_W'(imm);
        bus.in_mode   = 2'(mode);
        bus.out_ready = ordy;
        flush         = fl;
        #1;
        obs_data  = bus.out_data;
        obs_valid = bus.out_valid;
        obs_err   = bus.err;
        obs_rdy   = bus.in_ready;
        rdy_m = (exp_q.size() < 2) || (exp_q.size() == 2 && ordy);
        chk("out_valid", 64'(obs_valid), 64'(exp_q.size() > 0));
        if (exp_q.size() > 0) chk("out_data", 64'(obs_data), 64'(exp_q[0]));
        chk("in_ready", 64'(obs_rdy), 64'(rdy_m));
        chk("err", 64'(obs_err), 64'(m_err));
        acc = v && rdy_m;
        if (fl) begin
            exp_q.delete();
            m_held = 0;
            m_err  = 0;
        end else begin
            nerr = acc && m_held && (mode != 3);
            if (exp_q.size() > 0 && ordy) void'(exp_q.pop_front());
            if (acc) begin
                if (mode == 3 && !m_held) begin
                    m_held = 1;
                    m_hi   = longint'(imm);
                end else begin
                    exp_q.push_back(ref_ext(mode, longint'(imm), m_hi));
                    m_held = 0;
                end
            end
            m_err = nerr;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        exp_q.delete();
        m_held = 0;
        m_err  = 0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_data", 64'(bus.out_data), 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        chk("rst_ready", 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        rst_n         = 1'b0;
        flush         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_imm    = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b0;
        m_hi          = 0;
        do_reset();

        // SIGN sweep 0x00..0xF0
        for (int i = 0; i < 16; i++) begin
            cycle(1, i * 16, 0, 1, 0);
            if (i > 0) chk("sweep", 64'(obs_data), 64'((i - 1 >= 8 ? 16'hFF00 : 16'h0000) | ((i - 1) * 16)));
        end
        cycle(0, 0, 0, 1, 0);
        chk("sweep_last", 64'(obs_data), 64'h00FF_F0 & 64'hFFFF);

        // Individual modes
        cycle(1, 'h80, 0, 1, 0); cycle(0, 0, 0, 1, 0); chk("sign80", 64'(obs_data), 64'hFF80);
        cycle(1, 'h80, 1, 1, 0); cycle(0, 0, 0, 1, 0); chk("zero80", 64'(obs_data), 64'h0080);
        cycle(1, 'hC0, 2, 1, 0); cycle(0, 0, 0, 1, 0); chk("shl_c0", 64'(obs_data), 64'hFF80);
        cycle(1, 'h3F, 2, 1, 0); cycle(0, 0, 0, 1, 0); chk("shl_3f", 64'(obs_data), 64'h007E);

        // PAIR
        cycle(1, 'h12, 3, 1, 0);
        cycle(1, 'h34, 3, 1, 0); chk("pair_nov", 64'(obs_valid), 64'd0);
        cycle(0, 0, 0, 1, 0);    chk("pair_data", 64'(obs_data), 64'h1234);
        cycle(0, 0, 0, 1, 0);    chk("pair_once", 64'(obs_valid), 64'd0);

        // Broken pair
        cycle(1, 'h12, 3, 1, 0);
        cycle(1, 'h05, 0, 1, 0);
        cycle(1, 'hFE, 0, 1, 0); chk("brk_err", 64'(obs_err), 64'd1);
        chk("brk_data", 64'(obs_data), 64'h0005);
        cycle(0, 0, 0, 1, 0);    chk("brk_err_clr", 64'(obs_err), 64'd0);
        chk("brk_next", 64'(obs_data), 64'hFFFE);

        // Backpressure
        cycle(1, 1, 0, 0, 0);
        cycle(1, 2, 0, 0, 0);
        cycle(1, 3, 0, 0, 0); chk("bp_full", 64'(obs_rdy), 64'd0);
        cycle(1, 3, 0, 1, 0); chk("bp_o1", 64'(obs_data), 64'h0001);
        cycle(0, 0, 0, 1, 0); chk("bp_o2", 64'(obs_data), 64'h0002);
        cycle(0, 0, 0, 1, 0); chk("bp_o3", 64'(obs_data), 64'h0003);
        cycle(0, 0, 0, 1, 0);

        // Flush with a full buffer
        cycle(1, 7, 0, 0, 0);
        cycle(1, 8, 0, 0, 0);
        cycle(0, 0, 0, 0, 1); chk("fl_full", 64'(obs_valid), 64'd1);
        cycle(0, 0, 0, 0, 0); chk("fl_empty", 64'(obs_valid), 64'd0);

        // Reset in the middle of a pair
        cycle(1, 'h9A, 3, 1, 0);
        do_reset();
        cycle(1, 'h56, 3, 1, 0);
        cycle(1, 'h78, 3, 1, 0);
        cycle(0, 0, 0, 1, 0); chk("rst_pair", 64'(obs_data), 64'h5678);
        chk("rst_pair_err", 64'(obs_err), 64'd0);
        cycle(0, 0, 0, 1, 0); chk("rst_pair_err2", 64'(obs_err), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 800; i++) begin
            cycle(1'($urandom_range(0, 3) != 0),
                  int'($urandom_range(0, 255)),
                  ($urandom_range(0, 2) == 0) ? 3 : int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 39) == 0));
        end
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);
        cycle(0, 0, 0, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imm_extend_pipe.md
# imm_extend_pipe

Parametrised, pipelined immediate-extension unit: the successor to the combinational 8→16 sign extender. It widens an IN_W-bit immediate to OUT_W bits using one of four modes: sign, zero, sign-and-shift-left-1, or two-beat pair concatenation. It sits between the instruction decoder and the accumulator/ALU operand mux. Input and output use valid/ready handshakes, with a 2-entry output buffer so decode never stalls on a single-cycle ALU hold.

## Interface
- IN_W, default 8: immediate width; legal range 2..16.
- OUT_W, default 16: result width; requires IN_W ≤ OUT_W ≤ 2·IN_W.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of the held pair beat and the output buffer.
- in_valid  in  1  immediate beat offered.
- in_ready  out  1  unit can accept a beat this cycle.
- in_imm  in  IN_W  immediate value.
- in_mode  in  2  0 = SIGN, 1 = ZERO, 2 = SIGN_SHL1, 3 = PAIR.
- out_valid  out  1  buffer head is valid.
- out_ready  in  1  consumer takes the head this cycle.
- out_data  out  OUT_W  extended result at the buffer head.
- err  out  1  one-cycle pulse: a PAIR sequence was broken.

## Operation
- A beat is accepted when in_valid && in_ready. A result is popped when out_valid && out_ready.
- SIGN: replicate in_imm[IN_W-1] into bits OUT_W-1..IN_W.
- ZERO: fill the upper bits with 0.
- SIGN_SHL1: sign-extend, then shift left 1; bit 0 = 0, and the top bit produced by the shift is dropped.
- PAIR: two beats with mode 3.
  - Beat 1 (state IDLE → HI_HELD): store in_imm as hi. Nothing is pushed.
  - Beat 2 (HI_HELD → IDLE): push {hi, lo}, truncated to its low OUT_W bits.
- Broken pair: a beat in HI_HELD with mode ≠ PAIR.
  - err pulses the following cycle.
  - hi is discarded and state returns to IDLE.
  - The beat itself is processed normally in its own mode, so exactly one result is pushed.
- Output buffer: 2-entry FIFO, count 0..2, FIFO order preserved.
- flush: count ← 0, state ← IDLE, err ← 0. Any beat accepted in the same cycle is dropped. flush has priority over push and pop.
- Reset values: out_valid 0, out_data 0, err 0, state IDLE, count 0. in_ready is 1 from the first cycle after rst_n deasserts.
- Reset asserted mid-pair: the held hi is lost and no err is raised.

## Timing
- Latency: a beat accepted at edge N appears on out_data, with out_valid = 1, immediately after edge N.
- in_ready is combinational: (count < 2) || (count == 2 && out_ready). Push and pop in the same cycle at count 2 keeps count 2.
- Push and pop in the same cycle at count 1 keeps count 1, and the head advances.
- out_data is stable while out_valid && !out_ready.
- A PAIR beat 1 consumes an input slot even though it produces no output. It is still gated by in_ready.
- err is registered: high for exactly one cycle after the offending accept.

## Structure
- Shared package imm_pkg:
  - mode encoding constants MODE_SIGN, MODE_ZERO, MODE_SHL1, MODE_PAIR;
  - FSM state enum with states IDLE and HI_HELD.
- Sub-module imm_extend_core: combinational function of (imm, mode, hi) → OUT_W result. This is the direct generalisation of the old 8→16 extender.
- imm_extend_pipe holds the FSM, the hi register, and the 2-entry buffer.

## Test plan
- Sweep, IN_W = 8, OUT_W = 16, SIGN mode:
  - stimulus: in_imm from 0x00 stepping +0x10 for 16 beats, out_ready = 1;
  - required: out_data[15:8] = 0x00 for 0x00..0x70 and 0xFF for 0x80..0xF0, with low byte equal to in_imm.
- Modes:
  - SIGN 0x80 → 0xFF80;
  - ZERO 0x80 → 0x0080;
  - SHL1 0xC0 → 0xFF80;
  - SHL1 0x3F → 0x007E.
- PAIR 0x12 then PAIR 0x34 → a single output 0x1234; out_valid stays 0 after the first beat.
- Broken pair: PAIR 0x12, then SIGN 0x05 → err high for one cycle and one output 0x0005. A following SIGN 0xFE → 0xFFFE with no err.
- Backpressure:
  - out_ready = 0; offer SIGN 0x01, 0x02, 0x03 back-to-back → in_ready drops after two accepts and the third beat is held.
  - Raise out_ready → outputs 0x0001, 0x0002, 0x0003 in order.
- Flush and reset:
  - flush with count = 2 → out_valid 0 next cycle.
  - rst_n low after PAIR beat 1, then PAIR 0x56 and PAIR 0x78 → 0x5678 with no err.
